// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t    : fetch FSM states (IDLE, FETCH, HOLD)
//   NOP_INSTR        : value held in the instruction register out of reset
//   RESET_PC_DEFAULT : default word-aligned reset PC
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request (master -> memory)
//   imem_addr  : word address of the request, stable while imem_req is high
//   imem_ack   : memory returns imem_rdata this cycle (memory -> master)
//   imem_rdata : fetched instruction word
// Modports: master (fetch unit side), slave (memory side).
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational successor-PC selection for the fetch stage.
// Priority: jr > jump > pcsrc > pcplus4. All arithmetic wraps modulo 2^ADDR_W.
// Inputs : pcplus4, signimm, jtarget, rs_val, pcsrc, jump, jr
// Outputs: next_pc, misalign (JR selected with a non-word-aligned rs_val)
module next_pc_sel #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pcplus4,
  input  logic [ADDR_W-1:0] signimm,
  input  logic [25:0]       jtarget,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              pcsrc,
  input  logic              jump,
  input  logic              jr,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misalign
);

  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_target;

  // JR forces word alignment; the dropped low bits are reported instead.
  assign jr_target     = {rs_val[ADDR_W-1:2], 2'b00};
  assign jump_target   = {pcplus4[ADDR_W-1:28], jtarget, 2'b00};
  assign branch_target = pcplus4 + (signimm << 2);

  always_comb begin
    next_pc = pcplus4;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (pcsrc) begin
      next_pc = branch_target;
    end
  end

  assign misalign = jr && (rs_val[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches to a
// variable-latency instruction memory, holds the fetched word for decode and
// advances the PC (branch / jump / jr) when the core accepts the instruction.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   imem (master)        : imem_req/imem_addr out, imem_ack/imem_rdata in
//   instr, instr_valid   : held instruction and its valid flag
//   instr_accept         : core retires instr; control inputs sampled this cycle
//   pcsrc, jump, jr      : next-PC selects (jr > jump > pcsrc > pcplus4)
//   signimm, jtarget, rs_val : branch immediate, jump field, JR register value
//   pc, pcplus4          : address of held instr and its link value
//   jr_misalign          : 1-cycle pulse when an accepted JR had rs_val[1:0] != 0
// Optional feature (macro FETCH_STALL_CNT_EN): stall_cnt output counting
// FETCH cycles without imem_ack, saturating at all-ones.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  fetch_unit_if.master      imem,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_accept,
  input  logic              pcsrc,
  input  logic              jump,
  input  logic              jr,
  input  logic [ADDR_W-1:0] signimm,
  input  logic [25:0]       jtarget,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcplus4,
  output logic              jr_misalign
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              jr_misalign_q, jr_misalign_d;

  logic [ADDR_W-1:0] next_pc;
  logic              misalign;

  assign pcplus4 = pc_q + ADDR_W'(4);

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .pcplus4  (pcplus4),
    .signimm  (signimm),
    .jtarget  (jtarget),
    .rs_val   (rs_val),
    .pcsrc    (pcsrc),
    .jump     (jump),
    .jr       (jr),
    .next_pc  (next_pc),
    .misalign (misalign)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    req_d         = req_q;
    valid_d       = valid_q;
    jr_misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        // pc_q is the request address, so it stays put until the ack.
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = HOLD;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (instr_accept) begin
          pc_d          = next_pc;
          state_d       = FETCH;
          req_d         = 1'b1;
          valid_d       = 1'b0;
          jr_misalign_d = misalign;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC[ADDR_W-1:0];
      instr_q       <= NOP_INSTR;
      req_q         <= 1'b0;
      valid_q       <= 1'b0;
      jr_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      req_q         <= req_d;
      valid_q       <= valid_d;
      jr_misalign_q <= jr_misalign_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign jr_misalign    = jr_misalign_q;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == FETCH && !imem.imem_ack && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  // An ack while holding an instruction has no request behind it. An ack in
  // IDLE can only be the late response of a fetch abandoned by reset and is
  // dropped silently, since IDLE is entered only from reset.
  a_no_ack_in_hold: assert property (
    @(posedge clk) disable iff (!reset_n) !(state_q == HOLD && imem.imem_ack)
  );

endmodule
